i2c_seq_initializer: RTL and testbench

I2C_SEQ_INITIALIZER -- requirements
Module: i2c_seq_initializer

---
 rtl/i2c_seq_initializer.sv | 190 +++++++++++++++++++
 tb/tb_i2c_seq_initializer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_seq_initializer.sv
// I2C register-table writer: sends NUM_WORDS write frames {addr+W, word bytes MSB first} to one slave.
// Optional macro I2C_ACK_CHECK_EN enables NACK detection with per-word retries and o_error.
module i2c_seq_initializer #(
  parameter logic [6:0] DEV_ADDR   = 7'b0011010,
  parameter int         NUM_WORDS  = 7,
  parameter int         DATA_BYTES = 2,
  parameter int         CLK_DIV    = 1,
  parameter int         MAX_RETRY  = 2
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_start,
  input  logic [NUM_WORDS*DATA_BYTES*8-1:0]   i_table,
  output logic                                o_finished,
  output logic                                o_busy,
  output logic                                o_error,
  output logic                                o_sclk,
  inout  wire                                 io_sdat,
  output logic                                o_oen
);

  localparam int WORD_W  = DATA_BYTES * 8;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WORD_CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int BYTE_W  = $clog2(DATA_BYTES + 1);
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    IDLE, START, BIT_LO, BIT_HI, ACK_LO, ACK_HI, STOP1, STOP2, STOP3, DONE
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q;
  logic [2:0]           bit_q, bit_d;
  logic [BYTE_W-1:0]    byte_q, byte_d;
  logic [WORD_CW-1:0]   word_q, word_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 nack_q, nack_d;
  logic                 error_q, error_d;
  logic                 tick, nack, sda;
  logic [WORD_W-1:0]    cur_word, shifted;
  logic [7:0]           tx_byte;

`ifdef I2C_ACK_CHECK_EN
  assign nack    = io_sdat;
  assign o_error = error_q;
`else
  logic unused_sig;
  assign nack       = 1'b0;
  assign o_error    = 1'b0;
  assign unused_sig = io_sdat ^ error_q;
`endif

  assign tick     = (div_q == DIV_W'(CLK_DIV - 1));
  assign cur_word = i_table[int'(word_q) * WORD_W +: WORD_W];
  // byte_q 0 is the address byte; 1..DATA_BYTES walk the word from its top byte down
  assign shifted  = cur_word >> (8 * (DATA_BYTES - int'(byte_q)));
  assign tx_byte  = (byte_q == '0) ? {DEV_ADDR, 1'b0} : shifted[7:0];

  assign o_busy     = (state_q != IDLE) && (state_q != DONE);
  assign o_finished = (state_q == DONE);
  assign io_sdat    = o_oen ? sda : 1'bz;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      retry_q <= '0;
      nack_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      retry_q <= retry_d;
      nack_q  <= nack_d;
      error_q <= error_d;
      if (state_q == IDLE || state_q == DONE || tick)
        div_q <= '0;
      else
        div_q <= div_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    word_d  = word_q;
    retry_d = retry_q;
    nack_d  = nack_q;
    error_d = error_q;
    o_sclk  = 1'b1;
    sda     = 1'b1;
    o_oen   = 1'b1;
    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d = START;
          bit_d   = '0;
          byte_d  = '0;
          word_d  = '0;
          retry_d = '0;
          nack_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      START: begin
        sda = 1'b0;
        if (tick) begin
          state_d = BIT_LO;
          bit_d   = 3'd7;
          byte_d  = '0;
        end
      end
      BIT_LO: begin
        o_sclk = 1'b0;
        sda    = tx_byte[bit_q];
        if (tick) state_d = BIT_HI;
      end
      BIT_HI: begin
        sda = tx_byte[bit_q];
        if (tick) begin
          if (bit_q == 3'd0) begin
            state_d = ACK_LO;
          end else begin
            bit_d   = bit_q - 1'b1;
            state_d = BIT_LO;
          end
        end
      end
      ACK_LO: begin
        o_sclk = 1'b0;
        o_oen  = 1'b0;
        if (tick) state_d = ACK_HI;
      end
      ACK_HI: begin
        o_oen = 1'b0;
        if (tick) begin
          if (nack) begin
            nack_d  = 1'b1;
            state_d = STOP1;
          end else if (byte_q == BYTE_W'(DATA_BYTES)) begin
            state_d = STOP1;
          end else begin
            byte_d  = byte_q + 1'b1;
            bit_d   = 3'd7;
            state_d = BIT_LO;
          end
        end
      end
      STOP1: begin
        o_sclk = 1'b0;
        sda    = 1'b0;
        if (tick) state_d = STOP2;
      end
      STOP2: begin
        sda = 1'b0;
        if (tick) state_d = STOP3;
      end
      STOP3: begin
        // a NACKed frame repeats the same word until its retry budget runs out
        if (tick) begin
          if (nack_q) begin
            nack_d = 1'b0;
            if (retry_q >= RETRY_W'(MAX_RETRY)) begin
              state_d = DONE;
              error_d = 1'b1;
            end else begin
              retry_d = retry_q + 1'b1;
              state_d = START;
            end
          end else if (word_q >= WORD_CW'(NUM_WORDS - 1)) begin
            state_d = DONE;
          end else begin
            word_d  = word_q + 1'b1;
            retry_d = '0;
            state_d = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_seq_initializer.sv
// Bench for i2c_seq_initializer: table of full runs checked against a byte/timing model,
// plus hand sequences for the divided clock, restart from DONE and mid-frame reset.
module tb_i2c_seq_initializer;
  localparam int NW = 7;
  localparam int TW = NW * 16;
`ifdef I2C_ACK_CHECK_EN
  localparam bit ACKCHK = 1'b1;
`else
  localparam bit ACKCHK = 1'b0;
`endif

  // mode 0: slave ACKs all; 1: NACK word 2 first data byte once; 2: NACK every address byte
  typedef struct {
    logic [TW-1:0] tbl;
    int            mode;
    bit            poke;
    int            exp_frames;
    int            exp_cycles;
    logic          exp_err;
  } vec_t;

  vec_t vecs[5];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start0 = 1'b0, start1 = 1'b0;
  logic [TW-1:0] tbl0 = '0;
  logic [15:0]   tbl1 = 16'hBEEF;
  logic          fin0, busy0, err0, sclk0, oen0;
  logic          fin1, busy1, err1, sclk1, oen1;
  wire           sdat0, sdat1;
  logic          slave_bit;
  int            mode = 0;

  int            n_cmp = 0, n_fail = 0;
  int            frames = 0, frame_bytes = 0, bitc = 0;
  logic [7:0]    sh = '0;
  logic [7:0]    got[$];
  logic [7:0]    exp_q[$];
  logic          psclk = 1'b1, psda = 1'b1;
  bit            mon_clear = 1'b0;

  always #5 clk = ~clk;

  i2c_seq_initializer u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .i_table(tbl0),
    .o_finished(fin0), .o_busy(busy0), .o_error(err0), .o_sclk(sclk0),
    .io_sdat(sdat0), .o_oen(oen0)
  );

  i2c_seq_initializer #(.CLK_DIV(4), .NUM_WORDS(1)) u_div4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_table(tbl1),
    .o_finished(fin1), .o_busy(busy1), .o_error(err1), .o_sclk(sclk1),
    .io_sdat(sdat1), .o_oen(oen1)
  );

  assign sdat0 = oen0 ? 1'bz : slave_bit;
  assign sdat1 = oen1 ? 1'bz : 1'b0;

  always_comb begin
    slave_bit = 1'b0;
    if (mode == 1 && frames == 2 && frame_bytes == 2) slave_bit = 1'b1;
    if (mode == 2 && frame_bytes == 1) slave_bit = 1'b1;
  end

  // Bus monitor: START/STOP detection and byte capture on SCL rising while the master drives SDA
  always @(negedge clk) begin
    if (mon_clear || !rst_n) begin
      frames = 0; frame_bytes = 0; bitc = 0; sh = '0;
      got.delete();
    end else if (psclk && sclk0 && psda && !sdat0) begin
      frame_bytes = 0; bitc = 0;
    end else if (psclk && sclk0 && !psda && sdat0) begin
      frames++;
    end else if (!psclk && sclk0 && oen0) begin
      sh = {sh[6:0], sdat0};
      bitc++;
      if (bitc == 8) begin
        got.push_back(sh);
        frame_bytes++;
        bitc = 0;
      end
    end
    psclk = sclk0;
    psda  = sdat0;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic build_expected(input logic [TW-1:0] tbl, input int md);
    logic [7:0] hi, lo;
    exp_q.delete();
    for (int w = 0; w < NW; w++) begin
      hi = tbl[w*16+8 +: 8];
      lo = tbl[w*16 +: 8];
      if (ACKCHK && md == 2) begin
        for (int r = 0; r < 3; r++) exp_q.push_back(8'h34);
        break;
      end
      if (ACKCHK && md == 1 && w == 2) begin
        exp_q.push_back(8'h34);
        exp_q.push_back(hi);
      end
      exp_q.push_back(8'h34);
      exp_q.push_back(hi);
      exp_q.push_back(lo);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int cyc;
    int diffs;
    tbl0 = v.tbl;
    mode = v.mode;
    build_expected(v.tbl, v.mode);
    mon_clear = 1'b1;
    @(negedge clk); #1 mon_clear = 1'b0;
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    checkOutput($sformatf("v%0d_busy_after_start", idx), busy0, 1);
    checkOutput($sformatf("v%0d_fin_cleared", idx), fin0, 0);
    checkOutput($sformatf("v%0d_err_cleared", idx), err0, 0);
    cyc = 0;
    while (!fin0 && cyc < 3000) begin
      if (v.poke && cyc == 100) start0 = 1'b1;
      if (v.poke && cyc == 103) start0 = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start0 = 1'b0;
    checkOutput($sformatf("v%0d_cycles", idx), cyc, v.exp_cycles);
    checkOutput($sformatf("v%0d_busy_end", idx), busy0, 0);
    checkOutput($sformatf("v%0d_error", idx), err0, v.exp_err);
    checkOutput($sformatf("v%0d_frames", idx), frames, v.exp_frames);
    diffs = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got.size() || got[i] !== exp_q[i]) diffs++;
    checkOutput($sformatf("v%0d_byte_count", idx), got.size(), exp_q.size());
    checkOutput($sformatf("v%0d_byte_diffs", idx), diffs, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d_fin_held", idx), fin0, 1);
  endtask

  initial begin
    int   cyc;
    int   diffs;
    logic want;

    vecs[0] = '{tbl: 112'h0123_4567_89AB_CDEF_FEDC_BA98_7654, mode: 0, poke: 1'b0,
                exp_frames: 7, exp_cycles: 406, exp_err: 1'b0};
    vecs[1] = '{tbl: 112'hFFFF_0000_A5A5_5A5A_8001_7FFE_00FF, mode: 0, poke: 1'b1,
                exp_frames: 7, exp_cycles: 406, exp_err: 1'b0};
    vecs[2] = '{tbl: 112'h1111_2222_3333_4444_5555_6666_7777, mode: 1, poke: 1'b0,
                exp_frames: ACKCHK ? 8 : 7, exp_cycles: ACKCHK ? 446 : 406, exp_err: 1'b0};
    vecs[3] = '{tbl: 112'h0123_4567_89AB_CDEF_FEDC_BA98_7654, mode: 2, poke: 1'b0,
                exp_frames: ACKCHK ? 3 : 7, exp_cycles: ACKCHK ? 66 : 406, exp_err: ACKCHK};
    vecs[4] = '{tbl: 112'hFFFF_0000_A5A5_5A5A_8001_7FFE_00FF, mode: 0, poke: 1'b0,
                exp_frames: 7, exp_cycles: 406, exp_err: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_finished", fin0, 0);
    checkOutput("rst_busy", busy0, 0);
    checkOutput("rst_error", err0, 0);
    checkOutput("rst_sclk", sclk0, 1);
    checkOutput("rst_oen", oen0, 1);
    checkOutput("rst_sda", sdat0, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // divided clock: every phase holds for four cycles
    start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    checkOutput("div4_busy", busy1, 1);
    checkOutput("div4_start_sda", sdat1, 0);
    cyc = 0;
    diffs = 0;
    while (!fin1 && cyc < 3000) begin
      want = ((cyc / 4) % 2) == 0;
      if (cyc < 12 && sclk1 !== want) diffs++;
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("div4_phase_diffs", diffs, 0);
    checkOutput("div4_cycles", cyc, 232);
    checkOutput("div4_error", err1, 0);

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

    // i_start held while DONE restarts, then a reset lands in word 3
    mode = 0;
    tbl0 = vecs[1].tbl;
    mon_clear = 1'b1;
    @(negedge clk); #1 mon_clear = 1'b0;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    checkOutput("restart_busy", busy0, 1);
    checkOutput("restart_fin_cleared", fin0, 0);
    cyc = 0;
    while (!(frames == 3 && frame_bytes >= 1 && frame_bytes <= 2 && sclk0 && oen0) && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("reach_word3_bit_hi", (cyc < 2000), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_sclk", sclk0, 1);
    checkOutput("midrst_oen", oen0, 1);
    checkOutput("midrst_sda", sdat0, 1);
    checkOutput("midrst_busy", busy0, 0);
    checkOutput("midrst_fin", fin0, 0);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    applyStimulus(vecs[0], 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
